xorshift32_rewind: RTL
======================

# xorshift32_rewind

Iterative inverse of the XorShift32 generator (shifts a=13 left, b=17 right, c=5 left). Given a generator state and a step count, it walks the state backward one step per clock and returns the state that many steps earlier. It sits beside the forward xorshift32 generator in the RNG test and replay infrastructure, and is used to recover earlier seeds from an observed output stream.

## Interface
- Parameters:
  - `CNT_W`, default 16: width of the step-count input.
- Ports:
  - `clk`, input, 1: the only clock.
  - `rst`, input, 1: reset, asynchronous, active-high.
  - `start`, input, 1: request strobe. Sampled only while `ready`=1.
  - `state_in`, input, 32: state to rewind from. Captured with `start`.
  - `steps`, input, CNT_W: number of backward steps. Captured with `start`.
  - `ready`, output, 1: high in IDLE. Equal to !busy.
  - `busy`, output, 1: high while a rewind is in progress.
  - `done`, output, 1: one-cycle pulse when `state_out` becomes valid.
  - `state_out`, output, 32: rewound state. Held until the next accepted `start`.

## Operation
- Inverse of one forward step undoes the three stages in reverse order:
  - Undo c=5 left: x = y ^ y<<5 ^ y<<10 ^ y<<15 ^ y<<20 ^ y<<25 ^ y<<30.
  - Undo b=17 right: x = y ^ y>>17.
  - Undo a=13 left: x = y ^ y<<13 ^ y<<26.
- All shifts are logical, 32-bit, and truncating. Zero maps to zero.
- FSM states:
  - IDLE:
    - `ready`=1.
    - On `start`: load the working register with `state_in` and the counter with `steps`.
    - steps=0: go to FIN. Otherwise go to RUN.
  - RUN:
    - Each cycle, working register ← inv_step(working register) and counter decrements.
    - When the counter reaches 1 on the current cycle, go to FIN after that step.
  - FIN:
    - `state_out` ← working register, `done`=1, go to IDLE.
- `start` while busy is ignored. No queuing, and no change to the in-flight operation.
- `state_in` and `steps` changes after acceptance have no effect.
- steps = 2^CNT_W−1 is legal. The counter must not wrap or underflow.
- Reset values:
  - FSM IDLE, `ready`=1, `busy`=0, `done`=0.
  - `state_out`=0, working register=0, counter=0.
- Reset mid-RUN aborts immediately:
  - No `done` pulse is produced.
  - `state_out` returns to 0.

## Timing
- `start` accepted at edge t:
  - `busy`=1 from t+1.
  - `done` pulse and `state_out` valid in cycle t+N+1 for N≥1.
  - For N=0, `done` is in cycle t+1 and `state_out`=`state_in`.
- `busy` is high for N+1 cycles (RUN plus FIN). `ready` returns high in the cycle after `done`.
- Back-to-back:
  - `start` may be accepted in the first `ready` cycle after `done`.
  - Minimum issue interval is N+2 cycles.
- All outputs are registered. No combinational path from inputs to outputs.
- One backward step per cycle. The step is a single combinational XOR network of depth ≤7 XOR levels.

## Structure
- Shared package `xorshift32_pkg`, used by this block and the forward generator:
  - Shift constants: A=13, B=17, C=5.
  - Direction flags: LEFT_A=1, LEFT_B=0, LEFT_C=1.
  - Forward and inverse step functions.
- Sub-module `xorshift32_inv_step`:
  - Purely combinational, 32-bit in and 32-bit out.
  - Built from the package constants.
  - Unit-testable against the forward step: inv(fwd(x))=x.
- Top level holds:
  - FSM (3 states).
  - CNT_W-bit down-counter.
  - 32-bit working register.
  - 32-bit `state_out` register.
  - `done` flop.

## Test plan
- Reset release, then `state_in`=0x00042021, `steps`=1, `start` → `done` one cycle later than the start cycle + 1 (i.e. at t+2), `state_out`=0x00000001.
- `state_in`=0x04080601, `steps`=2 → `done` at t+3, `state_out`=0x00000001. Intermediate working value is 0x00042021.
- `steps`=0, `state_in`=0xDEADBEEF → `done` at t+1, `state_out`=0xDEADBEEF. `busy` is high for exactly 1 cycle.
- `state_in`=0 with `steps`=100 → `state_out`=0.
- Random seed, then 1000 forward steps through the generator model, then rewind 1000 → the original seed. `busy` is high for 1001 cycles.
- Reset behaviour:
  - Assert `start` again mid-RUN → ignored, and the result is unchanged.
  - Assert `rst` mid-RUN → no `done`, `state_out`=0, `ready`=1 in the cycle after release.
  - New request after reset → completes correctly.

Source files
------------

// File: rtl/xorshift32_pkg.sv
// Shared XorShift32 definitions for the forward generator and the rewind block.
// Holds the shift constants, their directions, the FSM state type of the
// rewind block, and the forward/inverse single-step functions.
package xorshift32_pkg;

    localparam int A = 13;
    localparam int B = 17;
    localparam int C = 5;

    localparam bit LEFT_A = 1'b1;
    localparam bit LEFT_B = 1'b0;
    localparam bit LEFT_C = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } rewind_state_e;

    function automatic logic [31:0] xs_shift(input logic [31:0] x, input int s, input bit left);
        return left ? (x << s) : (x >> s);
    endfunction

    function automatic logic [31:0] xs_fwd(input logic [31:0] x);
        logic [31:0] y;
        y = x ^ xs_shift(x, A, LEFT_A);
        y = y ^ xs_shift(y, B, LEFT_B);
        y = y ^ xs_shift(y, C, LEFT_C);
        return y;
    endfunction

    // Undo y = x ^ (x shift s): x = y ^ (y sh s) ^ (y sh 2s) ^ ... until the
    // shifted copy falls off the 32-bit word.
    function automatic logic [31:0] xs_undo(input logic [31:0] y, input int s, input bit left);
        logic [31:0] x;
        x = y;
        for (int k = 1; k < 32; k++) begin
            if (k * s < 32) begin
                x = x ^ xs_shift(y, k * s, left);
            end
        end
        return x;
    endfunction

    // Stages are undone in reverse order of the forward step.
    function automatic logic [31:0] xs_inv(input logic [31:0] y);
        logic [31:0] x;
        x = xs_undo(y, C, LEFT_C);
        x = xs_undo(x, B, LEFT_B);
        x = xs_undo(x, A, LEFT_A);
        return x;
    endfunction

endpackage

// File: rtl/xorshift32_rewind_if.sv
// Request/response bundle of the xorshift32 rewind block.
//   start     : request strobe (sampled while ready)
//   state_in  : state to rewind from
//   steps     : number of backward steps
//   ready     : idle, can accept start
//   busy      : rewind in progress
//   done      : one-cycle pulse, state_out valid
//   state_out : rewound state, held until the next accepted start
interface xorshift32_rewind_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic [31:0]      state_in;
    logic [CNT_W-1:0] steps;
    logic             ready;
    logic             busy;
    logic             done;
    logic [31:0]      state_out;

    modport master (
        output start, state_in, steps,
        input  ready, busy, done, state_out
    );

    modport slave (
        input  start, state_in, steps,
        output ready, busy, done, state_out
    );
endinterface

// File: rtl/xorshift32_inv_step.sv
// One backward XorShift32 step, purely combinational.
//   x_i : state after a forward step
//   y_o : state before that forward step
module xorshift32_inv_step
    import xorshift32_pkg::*;
(
    input  logic [31:0] x_i,
    output logic [31:0] y_o
);

    assign y_o = xs_inv(x_i);

endmodule

// File: rtl/xorshift32_rewind.sv
// Walks an XorShift32 state backward one step per clock.
//   clk    : clock
//   rst    : asynchronous active-high reset
//   rw_bus : request/response bundle (slave side)
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | ready, waiting for start
// RUN     | one inverse step per cycle, counter counts down to 1
// FIN     | done pulse visible, state_out valid, back to IDLE next
module xorshift32_rewind
    import xorshift32_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    xorshift32_rewind_if.slave  rw_bus
);

    rewind_state_e    state_q, state_d;
    logic [31:0]      work_q, work_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      out_q, out_d;
    logic             done_q, done_d;
    logic [31:0]      inv_w;

    xorshift32_inv_step u_inv_step (
        .x_i (work_q),
        .y_o (inv_w)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end

    // The result and done are registered on the edge that enters FIN, so both
    // are visible during the FIN cycle without any input-to-output path.
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rw_bus.start) begin
                    work_d = rw_bus.state_in;
                    cnt_d  = rw_bus.steps;
                    if (rw_bus.steps == '0) begin
                        state_d = ST_FIN;
                        out_d   = rw_bus.state_in;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                work_d = inv_w;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_FIN;
                    out_d   = inv_w;
                    done_d  = 1'b1;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign rw_bus.ready     = (state_q == ST_IDLE);
    assign rw_bus.busy      = (state_q != ST_IDLE);
    assign rw_bus.done      = done_q;
    assign rw_bus.state_out = out_q;

endmodule
